// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// uart_transmitter : FIFO-buffered 8N1/8O/8E serial transmitter, 1-2 stop bits
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_transmitter #(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_rate_signal,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic             baud_q;
  state_t           state_q;
  logic [7:0]       sh_q;
  logic [2:0]       cnt_q;
  logic             par_q;
  logic             stop_q;
  logic             tx_q;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic             baud_tick;
  logic             fifo_nonempty;
  logic             stop_last;
  logic             push;
  logic             pop;
  logic [7:0]       head;

  assign baud_tick     = baud_rate_signal & ~baud_q;
  assign fifo_nonempty = (count_q != '0);
  assign stop_last     = (STOP_BITS == 1) ? 1'b1 : stop_q;
  assign ready         = (count_q != DEPTH_C);
  assign push          = valid && ready;
  // Launch only from the registered count, so a byte written on the tick waits one bit period.
  assign pop           = baud_tick && fifo_nonempty &&
                         ((state_q == S_IDLE) || ((state_q == S_STOP) && stop_last));
  assign head          = mem_q[rd_ptr_q];
  assign tx            = tx_q;
  assign busy          = (state_q != S_IDLE) || fifo_nonempty;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q  <= 1'b1;
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      baud_q <= baud_rate_signal;
      if (baud_tick) begin
        case (state_q)
          S_IDLE: begin
            if (pop) begin
              sh_q    <= head;
              par_q   <= 1'b0;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end
          end
          S_START: begin
            tx_q    <= sh_q[0];
            par_q   <= sh_q[0];
            sh_q    <= {1'b0, sh_q[7:1]};
            cnt_q   <= 3'd0;
            state_q <= S_DATA;
          end
          S_DATA: begin
            if (cnt_q == 3'd7) begin
              if (PARITY != 0) begin
                tx_q    <= (PARITY == 1) ? ~par_q : par_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                stop_q  <= 1'b0;
                state_q <= S_STOP;
              end
            end else begin
              tx_q  <= sh_q[0];
              par_q <= par_q ^ sh_q[0];
              sh_q  <= {1'b0, sh_q[7:1]};
              cnt_q <= cnt_q + 3'd1;
            end
          end
          S_PARITY: begin
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
            state_q <= S_STOP;
          end
          S_STOP: begin
            if (stop_last) begin
              if (pop) begin
                sh_q    <= head;
                par_q   <= 1'b0;
                tx_q    <= 1'b0;
                state_q <= S_START;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              stop_q <= 1'b1;
            end
          end
          default: begin
            tx_q    <= 1'b1;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_transmitter : scoreboard bench, three instances (none/odd/even parity)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_r = 1'b0;
  logic       baud_run;
  logic       baud_hold;
  logic       baud;
  logic [7:0] din [3];
  logic [2:0] vld;
  logic [2:0] rdy;
  logic [2:0] txl;
  logic [2:0] bsy;
  logic       bprev;
  logic       tick_seen;

  exp_t exp_q [3][$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(negedge clk) baud_r = ~baud_r;
  assign baud = baud_run ? baud_r : baud_hold;

  // Bench-side edge detector: tick_seen is high in the cycle following a baud rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bprev     <= 1'b1;
      tick_seen <= 1'b0;
    end else begin
      tick_seen <= baud & ~bprev;
      bprev     <= baud;
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int P = g;
    localparam int S = (g == 1) ? 2 : 1;

    uart_transmitter #(
      .FIFO_DEPTH (4),
      .PARITY     (P),
      .STOP_BITS  (S)
    ) u_dut (
      .clk              (clk),
      .rst              (rst),
      .baud_rate_signal (baud),
      .data             (din[g]),
      .valid            (vld[g]),
      .ready            (rdy[g]),
      .tx               (txl[g]),
      .busy             (bsy[g])
    );

    int         ph  = 0;
    int         sn  = 0;
    int         gap = 0;
    logic [7:0] sh  = '0;
    exp_t       e;

    always @(negedge clk) begin
      if (rst) begin
        ph  = 0;
        sn  = 0;
        gap = 0;
      end else if (tick_seen) begin
        if (ph == 0) begin
          if (txl[g] == 1'b0) begin
            ph = 1;
            sh = '0;
            if (exp_q[g].size() > 0 && exp_q[g][0].b2b) chk("b2b_gap", gap, 0);
          end else begin
            gap++;
          end
        end else if (ph <= 8) begin
          sh[ph-1] = txl[g];
          ph++;
          if (ph == 9 && P == 0) ph = 10;
        end else if (ph == 9) begin
          if (exp_q[g].size() > 0) chk("parity_bit", int'(txl[g]), int'(exp_q[g][0].p));
          ph = 10;
        end else begin
          chk("stop_bit", int'(txl[g]), 1);
          sn++;
          if (sn == S) begin
            chk("frame_expected", int'(exp_q[g].size() != 0), 1);
            if (exp_q[g].size() != 0) begin
              e = exp_q[g].pop_front();
              chk("rx_data", int'(sh), int'(e.d));
            end
            ph  = 0;
            sn  = 0;
            gap = 0;
          end
        end
      end
    end
  end

  // Called at a negedge; leaves at the negedge after the accepting posedge.
  task automatic send(input int g, input logic [7:0] d, input logic p, input logic b2b);
    int t = 0;
    while (!rdy[g] && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", int'(rdy[g]), 1);
    if (rdy[g]) begin
      din[g] = d;
      vld[g] = 1'b1;
      exp_q[g].push_back('{d: d, p: p, b2b: b2b});
      @(negedge clk);
      vld[g] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int g);
    int t = 0;
    while (bsy[g] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("busy_falls", int'(bsy[g]), 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int t;
    rst       = 1'b1;
    vld       = '0;
    baud_run  = 1'b0;
    baud_hold = 1'b0;
    for (int i = 0; i < 3; i++) din[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_tx", int'(txl[i]), 1);
      chk("reset_ready", int'(rdy[i]), 1);
      chk("reset_busy", int'(bsy[i]), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    baud_run = 1'b1;

    // 0x41 on all three; odd parity -> 1, even parity -> 0; second byte checks stop length
    send(0, 8'h41, 1'b0, 1'b0);
    send(1, 8'h41, 1'b1, 1'b0);
    send(2, 8'h41, 1'b0, 1'b0);
    send(1, 8'hC3, 1'b1, 1'b1);
    send(2, 8'h07, 1'b1, 1'b1);
    wait_idle(0);
    wait_idle(1);
    wait_idle(2);

    send(0, 8'h41, 1'b0, 1'b0);
    send(0, 8'hA5, 1'b0, 1'b1);
    send(0, 8'h00, 1'b0, 1'b1);
    send(0, 8'hFF, 1'b0, 1'b1);
    wait_idle(0);

    // FIFO full with baud frozen low; fifth byte must be dropped
    baud_run  = 1'b0;
    baud_hold = 1'b0;
    @(negedge clk);
    send(0, 8'h11, 1'b0, 1'b0);
    send(0, 8'h22, 1'b0, 1'b1);
    send(0, 8'h33, 1'b0, 1'b1);
    send(0, 8'h44, 1'b0, 1'b1);
    chk("full_ready", int'(rdy[0]), 0);
    din[0] = 8'h55;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    chk("full_ready_hold", int'(rdy[0]), 0);
    chk("full_tx_idle", int'(txl[0]), 1);
    baud_run = 1'b1;
    wait_idle(0);

    // Write lands on the same edge as the launch pop
    baud_run  = 1'b0;
    baud_hold = 1'b0;
    @(negedge clk);
    send(0, 8'h12, 1'b0, 1'b0);
    baud_hold = 1'b1;
    din[0]    = 8'h34;
    vld[0]    = 1'b1;
    exp_q[0].push_back('{d: 8'h34, p: 1'b0, b2b: 1'b1});
    @(negedge clk);
    vld[0] = 1'b0;
    chk("simul_tx_start", int'(txl[0]), 0);
    chk("simul_busy", int'(bsy[0]), 1);
    baud_run = 1'b1;
    wait_idle(0);

    // Asynchronous reset in the middle of 0xA5 with a full FIFO behind it
    send(0, 8'hA5, 1'b0, 1'b0);
    send(0, 8'h66, 1'b0, 1'b1);
    send(0, 8'h77, 1'b0, 1'b1);
    send(0, 8'h88, 1'b0, 1'b1);
    send(0, 8'h99, 1'b0, 1'b1);
    chk("pre_reset_ready", int'(rdy[0]), 0);
    t = 0;
    while (txl[0] != 1'b0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("pre_reset_tx_low", int'(txl[0]), 0);
    rst = 1'b1;
    #1;
    chk("reset_mid_tx", int'(txl[0]), 1);
    chk("reset_mid_ready", int'(rdy[0]), 1);
    chk("reset_mid_busy", int'(bsy[0]), 0);
    exp_q[0].delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(0, 8'h3C, 1'b0, 1'b0);
    wait_idle(0);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 3; i++) chk("queue_drained", exp_q[i].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
